// File: rtl/adc_avg_pkg.sv
// -----------------------------------------------------------------------------
// adc_avg_pkg
// Shared definitions for the ADC moving-average filter:
//   SAMPLE_W    - width of one converted ADC sample
//   avg_state_t - window state (FILL while populating, RUN once full)
//   sat_sub     - unsigned subtract clamped at zero (hysteresis release level)
// -----------------------------------------------------------------------------
package adc_avg_pkg;

  localparam int SAMPLE_W = 12;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } avg_state_t;

  // a - b, clamped at 0 so a low threshold never wraps to a huge level.
  function automatic logic [SAMPLE_W-1:0] sat_sub(input logic [SAMPLE_W-1:0] a,
                                                  input logic [SAMPLE_W-1:0] b);
    return (a > b) ? (a - b) : '0;
  endfunction

endpackage

// File: rtl/sample_ring.sv
// -----------------------------------------------------------------------------
// sample_ring
// N = 2^LOG2_N entry register array holding the most recent raw samples.
// The entry at wr_ptr_i is presented combinationally on rd_old_o so the
// caller can subtract the sample it is about to overwrite in the same cycle.
// Ports:
//   clk_i      clock
//   reset_i    synchronous active-high reset, zeroes every entry
//   clear_i    synchronous flush, zeroes every entry
//   wr_en_i    write wr_data_i into entry wr_ptr_i
//   wr_ptr_i   write / read-old index
//   wr_data_i  sample to store
//   rd_old_o   current contents of entry wr_ptr_i
// -----------------------------------------------------------------------------
module sample_ring
  import adc_avg_pkg::*;
#(
  parameter int LOG2_N = 3
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                clear_i,
  input  logic                wr_en_i,
  input  logic [LOG2_N-1:0]   wr_ptr_i,
  input  logic [SAMPLE_W-1:0] wr_data_i,
  output logic [SAMPLE_W-1:0] rd_old_o
);

  localparam int N = 1 << LOG2_N;

  logic [SAMPLE_W-1:0] ring_q [N];

  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      for (int i = 0; i < N; i++) begin
        ring_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      ring_q[wr_ptr_i] <= wr_data_i;
    end
  end

  assign rd_old_o = ring_q[wr_ptr_i];

endmodule

// File: rtl/adc_moving_avg.sv
// -----------------------------------------------------------------------------
// adc_moving_avg
// Moving-average filter behind the ADC SPI controller. Keeps the last
// N = 2^LOG2_N samples with a running sum and publishes sum/N, a threshold
// flag with hysteresis and a window-filled flag. Every offered sample is
// taken (no backpressure); results appear one edge after sample_valid.
//
// Parameters:
//   LOG2_N    log2 of window length (1..6)
//   THR_HYST  hysteresis band for above_thr, in LSBs (0..4095)
// Ports:
//   clk           system clock
//   reset         synchronous active-high reset
//   sample_in     converted ADC sample
//   sample_valid  one-cycle strobe qualifying sample_in
//   clear         synchronous window flush (wins over sample_valid)
//   threshold     compare level for above_thr
//   avg_out       window average (truncating)
//   avg_valid     one-cycle strobe, avg_out updated
//   above_thr     level flag with hysteresis
//   filled        window fully populated
//   min_out       minimum raw sample since clear/reset
//   max_out       maximum raw sample since clear/reset
//
// Build option: define PEAK_HOLD_EN to enable min/max tracking; without it
// min_out/max_out are tied to 12'hFFF / 0.
// -----------------------------------------------------------------------------
module adc_moving_avg
  import adc_avg_pkg::*;
#(
  parameter int LOG2_N   = 3,
  parameter int THR_HYST = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid,
  input  logic                clear,
  input  logic [SAMPLE_W-1:0] threshold,
  output logic [SAMPLE_W-1:0] avg_out,
  output logic                avg_valid,
  output logic                above_thr,
  output logic                filled,
  output logic [SAMPLE_W-1:0] min_out,
  output logic [SAMPLE_W-1:0] max_out
);

  localparam int N     = 1 << LOG2_N;
  localparam int SUM_W = SAMPLE_W + LOG2_N;
  localparam int CNT_W = LOG2_N + 1;

  localparam logic [CNT_W-1:0]    N_CNT = CNT_W'(N);
  localparam logic [SAMPLE_W-1:0] HYST  = SAMPLE_W'(THR_HYST);

  avg_state_t          state_q,   state_d;
  logic [CNT_W-1:0]    count_q,   count_d;
  logic [LOG2_N-1:0]   wr_ptr_q,  wr_ptr_d;
  logic [SUM_W-1:0]    sum_q,     sum_d;
  logic [SAMPLE_W-1:0] avg_q,     avg_d;
  logic                avg_vld_q, avg_vld_d;
  logic                above_q,   above_d;
  logic                filled_q,  filled_d;

  logic [SAMPLE_W-1:0] rd_old;
  logic                accept;

  // clear drops any sample offered in the same cycle.
  assign accept = sample_valid && !clear;

  sample_ring #(
    .LOG2_N (LOG2_N)
  ) u_ring (
    .clk_i     (clk),
    .reset_i   (reset),
    .clear_i   (clear),
    .wr_en_i   (accept),
    .wr_ptr_i  (wr_ptr_q),
    .wr_data_i (sample_in),
    .rd_old_o  (rd_old)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    wr_ptr_d  = wr_ptr_q;
    sum_d     = sum_q;
    avg_d     = avg_q;
    avg_vld_d = 1'b0;
    above_d   = above_q;
    filled_d  = filled_q;

    if (clear) begin
      // avg_out and above_thr deliberately hold their last value.
      state_d  = FILL;
      count_d  = '0;
      wr_ptr_d = '0;
      sum_d    = '0;
      filled_d = 1'b0;
    end else if (sample_valid) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      case (state_q)
        FILL: begin
          sum_d   = sum_q + SUM_W'(sample_in);
          count_d = count_q + 1'b1;
          if (count_d == N_CNT) begin
            state_d   = RUN;
            filled_d  = 1'b1;
            avg_vld_d = 1'b1;
          end
        end
        RUN: begin
          // rd_old is already contained in sum_q, so this never underflows.
          sum_d     = sum_q - SUM_W'(rd_old) + SUM_W'(sample_in);
          avg_vld_d = 1'b1;
        end
      endcase

      if (avg_vld_d) begin
        avg_d = sum_d[SUM_W-1:LOG2_N];
        if (avg_d > threshold) begin
          above_d = 1'b1;
        end else if (avg_d < sat_sub(threshold, HYST)) begin
          above_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FILL;
      count_q   <= '0;
      wr_ptr_q  <= '0;
      sum_q     <= '0;
      avg_q     <= '0;
      avg_vld_q <= 1'b0;
      above_q   <= 1'b0;
      filled_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      sum_q     <= sum_d;
      avg_q     <= avg_d;
      avg_vld_q <= avg_vld_d;
      above_q   <= above_d;
      filled_q  <= filled_d;
    end
  end

  assign avg_out   = avg_q;
  assign avg_valid = avg_vld_q;
  assign above_thr = above_q;
  assign filled    = filled_q;

`ifdef PEAK_HOLD_EN
  logic [SAMPLE_W-1:0] min_q, max_q;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      min_q <= '1;
      max_q <= '0;
    end else if (accept) begin
      if (sample_in < min_q) min_q <= sample_in;
      if (sample_in > max_q) max_q <= sample_in;
    end
  end

  assign min_out = min_q;
  assign max_out = max_q;
`else
  assign min_out = '1;
  assign max_out = '0;
`endif

endmodule

// File: tb/tb_adc_moving_avg.sv
// -----------------------------------------------------------------------------
// tb_adc_moving_avg
// Self-checking bench for adc_moving_avg with LOG2_N=2, THR_HYST=16.
// Directed sequences followed by randomized traffic, all compared against a
// queue-based window model. Honours PEAK_HOLD_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_adc_moving_avg;

  localparam int LOG2_N = 2;
  localparam int N      = 1 << LOG2_N;
  localparam int HYST   = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] sample_in = '0;
  logic        sample_valid = 1'b0;
  logic        clear = 1'b0;
  logic [11:0] threshold = 12'hFFF;
  logic [11:0] avg_out;
  logic        avg_valid;
  logic        above_thr;
  logic        filled;
  logic [11:0] min_out;
  logic [11:0] max_out;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int win[$];
  int e_avg = 0, e_vld = 0, e_above = 0, e_filled = 0;
  int e_min = 4095, e_max = 0;

  adc_moving_avg #(
    .LOG2_N   (LOG2_N),
    .THR_HYST (HYST)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .clear        (clear),
    .threshold    (threshold),
    .avg_out      (avg_out),
    .avg_valid    (avg_valid),
    .above_thr    (above_thr),
    .filled       (filled),
    .min_out      (min_out),
    .max_out      (max_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model(input bit r, input bit v, input int d, input bit c);
    int s, lvl, tmp;
    if (r) begin
      win.delete();
      e_avg = 0; e_vld = 0; e_above = 0; e_filled = 0;
      e_min = 4095; e_max = 0;
    end else if (c) begin
      win.delete();
      e_vld = 0; e_filled = 0;
      e_min = 4095; e_max = 0;
    end else if (v) begin
      win.push_back(d);
      if (win.size() > N) tmp = win.pop_front();
`ifdef PEAK_HOLD_EN
      if (d < e_min) e_min = d;
      if (d > e_max) e_max = d;
`endif
      if (win.size() == N) begin
        s = 0;
        foreach (win[i]) s += win[i];
        e_avg = s / N;
        e_vld = 1;
        e_filled = 1;
        lvl = (int'(threshold) > HYST) ? int'(threshold) - HYST : 0;
        if (e_avg > int'(threshold)) e_above = 1;
        else if (e_avg < lvl) e_above = 0;
      end else begin
        e_vld = 0;
      end
    end else begin
      e_vld = 0;
    end
  endtask

  // One clock: drive on the falling edge, check 1 time unit after the rise.
  task automatic step(input bit r, input bit v, input int d, input bit c);
    @(negedge clk);
    reset = r;
    sample_valid = v;
    sample_in = 12'(d);
    clear = c;
    model(r, v, d, c);
    @(posedge clk);
    #1;
    check("avg_valid", 32'(avg_valid), 32'(e_vld));
    check("avg_out",   32'(avg_out),   32'(e_avg));
    check("above_thr", 32'(above_thr), 32'(e_above));
    check("filled",    32'(filled),    32'(e_filled));
    check("min_out",   32'(min_out),   32'(e_min));
    check("max_out",   32'(max_out),   32'(e_max));
  endtask

  initial begin
    int d;
    bit r, v, c;

    // Reset state
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check("rst_min", 32'(min_out), 32'hFFF);
    check("rst_max", 32'(max_out), 32'h0);
    check("rst_avg", 32'(avg_out), 32'h0);

    // Fill: 100,200,300,400 -> single avg_valid with 250
    step(0, 1, 100, 0);
    step(0, 1, 200, 0);
    step(0, 1, 300, 0);
    check("fill_novld", 32'(avg_valid), 32'h0);
    step(0, 1, 400, 0);
    check("fill_avg250", 32'(avg_out), 32'd250);
    check("fill_filled", 32'(filled), 32'h1);

    // RUN replacement and full-scale window
    step(0, 1, 800, 0);
    check("run_avg425", 32'(avg_out), 32'd425);
    for (int i = 0; i < 4; i++) step(0, 1, 4095, 0);
    check("fullscale", 32'(avg_out), 32'd4095);

    // Hysteresis around threshold 300
    threshold = 12'd300;
    for (int i = 0; i < 4; i++) step(0, 1, 301, 0);
    check("hyst_set", 32'(above_thr), 32'h1);
    for (int i = 0; i < 4; i++) step(0, 1, 290, 0);
    check("hyst_hold", 32'(above_thr), 32'h1);
    for (int i = 0; i < 4; i++) step(0, 1, 283, 0);
    check("hyst_avg283", 32'(avg_out), 32'd283);
    check("hyst_clr", 32'(above_thr), 32'h0);

    // clear wins over a simultaneous sample
    step(0, 1, 999, 1);
    check("clr_filled", 32'(filled), 32'h0);
    check("clr_avghold", 32'(avg_out), 32'd283);
    for (int i = 0; i < 4; i++) step(0, 1, 8, 0);
    check("clr_avg8", 32'(avg_out), 32'd8);

    // Back-to-back ramp from an empty window
    step(0, 0, 0, 1);
    for (int i = 0; i < 20; i++) step(0, 1, i, 0);
    check("ramp_avg17", 32'(avg_out), 32'd17);

    // Peak hold
    step(0, 0, 0, 1);
    step(0, 1, 500, 0);
    step(0, 1, 12, 0);
    step(0, 1, 4000, 0);
    step(0, 1, 7, 0);
`ifdef PEAK_HOLD_EN
    check("peak_min", 32'(min_out), 32'd7);
    check("peak_max", 32'(max_out), 32'd4000);
`else
    check("peak_min", 32'(min_out), 32'hFFF);
    check("peak_max", 32'(max_out), 32'h0);
`endif
    step(0, 0, 0, 1);
    check("peak_clr_min", 32'(min_out), 32'hFFF);
    check("peak_clr_max", 32'(max_out), 32'h0);

    // Reset mid-window
    step(0, 1, 1000, 0);
    step(0, 1, 2000, 0);
    step(1, 1, 3000, 0);
    check("midrst_vld", 32'(avg_valid), 32'h0);
    check("midrst_avg", 32'(avg_out), 32'h0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) threshold = 12'($urandom_range(0, 4095));
      r = ($urandom_range(0, 149) == 0);
      c = ($urandom_range(0, 39) == 0);
      v = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 7))
        0:       d = 0;
        1:       d = 4095;
        2:       d = int'(threshold) + $urandom_range(0, 40) - 20;
        default: d = $urandom_range(0, 4095);
      endcase
      if (d < 0) d = 0;
      if (d > 4095) d = 4095;
      step(r, v, d, c);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
